// File: rtl/cdc_pkg.sv
// Shared CDC constants: default synchronizer depth, default bus width and minimum legal depth.
package cdc_pkg;

  localparam int unsigned DSYNC_NUM_STAGES_DEF = 2;
  localparam int unsigned DSYNC_BUS_WIDTH_DEF  = 8;
  localparam int unsigned DSYNC_MIN_STAGES     = 2;

endpackage : cdc_pkg

// File: rtl/data_sync_pulse_if.sv
// Source-to-destination bus crossing signals for data_sync_pulse.
// BUS_ERR only exists when DSYNC_ERR_EN is defined.
interface data_sync_pulse_if #(
  parameter int unsigned BUS_WIDTH = cdc_pkg::DSYNC_BUS_WIDTH_DEF
);

  logic [BUS_WIDTH-1:0] UNSYNC_BUS;
  logic                 BUS_ENABLE;
  logic [BUS_WIDTH-1:0] SYNC_BUS;
  logic                 ENABLE_PULSE;
`ifdef DSYNC_ERR_EN
  logic                 BUS_ERR;
`endif

  modport master (
    output UNSYNC_BUS,
    output BUS_ENABLE,
    input  SYNC_BUS,
`ifdef DSYNC_ERR_EN
    input  BUS_ERR,
`endif
    input  ENABLE_PULSE
  );

  modport slave (
    input  UNSYNC_BUS,
    input  BUS_ENABLE,
    output SYNC_BUS,
`ifdef DSYNC_ERR_EN
    output BUS_ERR,
`endif
    output ENABLE_PULSE
  );

endinterface : data_sync_pulse_if

// File: rtl/bit_sync_chain.sv
// Single-bit multi-flop synchronizer: NUM_STAGES flops shifting d_i to q_o, async active-low reset.
module bit_sync_chain
  import cdc_pkg::*;
#(
  parameter int unsigned NUM_STAGES = DSYNC_NUM_STAGES_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [NUM_STAGES-1:0] sync_q;
  logic [NUM_STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[NUM_STAGES-2:0], d_i};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q[NUM_STAGES-1];

endmodule : bit_sync_chain

// File: rtl/data_sync_pulse.sv
// Multi-bit CDC receiver: synchronizes a level enable, captures the bus on its rising edge and
// emits a one-cycle ENABLE_PULSE. Optional sticky hold-window check enabled by DSYNC_ERR_EN.
module data_sync_pulse
  import cdc_pkg::*;
#(
  parameter int unsigned NUM_STAGES = DSYNC_NUM_STAGES_DEF,
  parameter int unsigned BUS_WIDTH  = DSYNC_BUS_WIDTH_DEF
) (
  input  logic                     CLK,
  input  logic                     RST,
  data_sync_pulse_if.slave         dsync
);

  if (NUM_STAGES < DSYNC_MIN_STAGES) begin : g_stage_chk
    $fatal(1, "data_sync_pulse: NUM_STAGES below DSYNC_MIN_STAGES");
  end

  logic                 en_s;
  logic                 rise;
  logic                 pulse_q,        pulse_d;
  logic                 enable_pulse_q, enable_pulse_d;
  logic [BUS_WIDTH-1:0] sync_bus_q,     sync_bus_d;

  bit_sync_chain #(
    .NUM_STAGES (NUM_STAGES)
  ) u_en_sync (
    .clk_i  (CLK),
    .rst_ni (RST),
    .d_i    (dsync.BUS_ENABLE),
    .q_o    (en_s)
  );

  always_comb begin
    rise           = en_s & ~pulse_q;
    pulse_d        = en_s;
    enable_pulse_d = rise;
    sync_bus_d     = rise ? dsync.UNSYNC_BUS : sync_bus_q;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      pulse_q        <= 1'b0;
      enable_pulse_q <= 1'b0;
      sync_bus_q     <= '0;
    end else begin
      pulse_q        <= pulse_d;
      enable_pulse_q <= enable_pulse_d;
      sync_bus_q     <= sync_bus_d;
    end
  end

  assign dsync.SYNC_BUS     = sync_bus_q;
  assign dsync.ENABLE_PULSE = enable_pulse_q;

`ifdef DSYNC_ERR_EN
  logic bus_err_q, bus_err_d;

  // Bus must match the captured value for as long as the synchronized enable stays high.
  always_comb begin
    bus_err_d = bus_err_q | (en_s & pulse_q & (dsync.UNSYNC_BUS != sync_bus_q));
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      bus_err_q <= 1'b0;
    end else begin
      bus_err_q <= bus_err_d;
    end
  end

  assign dsync.BUS_ERR = bus_err_q;
`endif

endmodule : data_sync_pulse

// File: tb/tb_data_sync_pulse.sv
// Self-checking bench for data_sync_pulse (NUM_STAGES=2, BUS_WIDTH=8); scoreboard of expected captures.
module tb_data_sync_pulse;

  logic CLK;
  logic RST;

  int checks;
  int errors;
  int pulse_cnt;

  logic [7:0] exp_q[$];

  data_sync_pulse_if #(.BUS_WIDTH(8)) bus_if ();

  data_sync_pulse #(
    .NUM_STAGES (2),
    .BUS_WIDTH  (8)
  ) dut (
    .CLK   (CLK),
    .RST   (RST),
    .dsync (bus_if.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Scoreboard consumer: every pulse must match the oldest pending expected capture.
  always @(posedge CLK) begin
    #1;
    if (bus_if.ENABLE_PULSE === 1'b1) begin
      pulse_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_pulse: got pulse with SYNC_BUS=%h, expected no pulse", bus_if.SYNC_BUS);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (bus_if.SYNC_BUS !== e) begin
          errors++;
          $display("FAIL sb_capture: SYNC_BUS=%h expected %h", bus_if.SYNC_BUS, e);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b0;
    bus_if.BUS_ENABLE = 1'b1;
    bus_if.UNSYNC_BUS = 8'hA5;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      checks++;
      if (bus_if.SYNC_BUS !== 8'h00 || bus_if.ENABLE_PULSE !== 1'b0) begin
        errors++;
        $display("FAIL reset_outputs: SYNC_BUS=%h PULSE=%b expected 00/0",
                 bus_if.SYNC_BUS, bus_if.ENABLE_PULSE);
      end
`ifdef DSYNC_ERR_EN
      checks++;
      if (bus_if.BUS_ERR !== 1'b0) begin
        errors++;
        $display("FAIL reset_bus_err: BUS_ERR=%b expected 0", bus_if.BUS_ERR);
      end
`endif
    end
    bus_if.BUS_ENABLE = 1'b0;
    RST = 1'b1;
    tick(4);
  endtask

  task automatic test_basic();
    bus_if.UNSYNC_BUS = 8'h3C;
    bus_if.BUS_ENABLE = 1'b1;
    exp_q.push_back(8'h3C);
    for (int e = 1; e <= 4; e++) begin
      tick(1);
      checks++;
      if (bus_if.ENABLE_PULSE !== (e == 3)) begin
        errors++;
        $display("FAIL basic_latency_E%0d: PULSE=%b expected %b", e, bus_if.ENABLE_PULSE, (e == 3));
      end
      if (e >= 3) begin
        checks++;
        if (bus_if.SYNC_BUS !== 8'h3C) begin
          errors++;
          $display("FAIL basic_sync_bus_E%0d: SYNC_BUS=%h expected 3c", e, bus_if.SYNC_BUS);
        end
      end
    end
`ifdef DSYNC_ERR_EN
    checks++;
    if (bus_if.BUS_ERR !== 1'b0) begin
      errors++;
      $display("FAIL basic_no_err: BUS_ERR=%b expected 0", bus_if.BUS_ERR);
    end
`endif
    bus_if.BUS_ENABLE = 1'b0;
    tick(5);
    checks++;
    if (bus_if.SYNC_BUS !== 8'h3C) begin
      errors++;
      $display("FAIL fall_no_change: SYNC_BUS=%h expected 3c", bus_if.SYNC_BUS);
    end
  endtask

  task automatic test_long_enable();
    int base;
    base = pulse_cnt;
    bus_if.UNSYNC_BUS = 8'hC3;
    bus_if.BUS_ENABLE = 1'b1;
    exp_q.push_back(8'hC3);
    tick(20);
    checks++;
    if (pulse_cnt - base !== 1) begin
      errors++;
      $display("FAIL long_single_pulse: pulses=%0d expected 1", pulse_cnt - base);
    end
    bus_if.BUS_ENABLE = 1'b0;
    tick(3);
    base = pulse_cnt;
    bus_if.UNSYNC_BUS = 8'h5A;
    bus_if.BUS_ENABLE = 1'b1;
    exp_q.push_back(8'h5A);
    tick(8);
    checks++;
    if (pulse_cnt - base !== 1) begin
      errors++;
      $display("FAIL second_single_pulse: pulses=%0d expected 1", pulse_cnt - base);
    end
    checks++;
    if (bus_if.SYNC_BUS !== 8'h5A) begin
      errors++;
      $display("FAIL second_capture: SYNC_BUS=%h expected 5a", bus_if.SYNC_BUS);
    end
    bus_if.BUS_ENABLE = 1'b0;
    tick(5);
  endtask

  task automatic test_midop_reset();
    int base;
    base = pulse_cnt;
    bus_if.UNSYNC_BUS = 8'h96;
    bus_if.BUS_ENABLE = 1'b1;
    exp_q.push_back(8'h96);
    tick(2);
    RST = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick(1);
      checks++;
      if (bus_if.ENABLE_PULSE !== 1'b0 || bus_if.SYNC_BUS !== 8'h00) begin
        errors++;
        $display("FAIL midreset_held: PULSE=%b SYNC_BUS=%h expected 0/00",
                 bus_if.ENABLE_PULSE, bus_if.SYNC_BUS);
      end
    end
    RST = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      tick(1);
      checks++;
      if (bus_if.ENABLE_PULSE !== (e == 3)) begin
        errors++;
        $display("FAIL midreset_release_E%0d: PULSE=%b expected %b", e, bus_if.ENABLE_PULSE, (e == 3));
      end
    end
    checks++;
    if (pulse_cnt - base !== 1 || bus_if.SYNC_BUS !== 8'h96) begin
      errors++;
      $display("FAIL midreset_result: pulses=%0d SYNC_BUS=%h expected 1/96",
               pulse_cnt - base, bus_if.SYNC_BUS);
    end
    bus_if.BUS_ENABLE = 1'b0;
    tick(5);
  endtask

  task automatic test_bus_ignored();
    int base;
    base = pulse_cnt;
    bus_if.UNSYNC_BUS = 8'h11;
    tick(2);
    bus_if.UNSYNC_BUS = 8'h22;
    tick(4);
    checks++;
    if (bus_if.SYNC_BUS !== 8'h96 || pulse_cnt != base) begin
      errors++;
      $display("FAIL bus_ignored: SYNC_BUS=%h pulses=%0d expected 96/0",
               bus_if.SYNC_BUS, pulse_cnt - base);
    end
`ifdef DSYNC_ERR_EN
    checks++;
    if (bus_if.BUS_ERR !== 1'b0) begin
      errors++;
      $display("FAIL bus_ignored_no_err: BUS_ERR=%b expected 0", bus_if.BUS_ERR);
    end
`endif
  endtask

`ifdef DSYNC_ERR_EN
  task automatic test_bus_err();
    bus_if.UNSYNC_BUS = 8'h3C;
    bus_if.BUS_ENABLE = 1'b1;
    exp_q.push_back(8'h3C);
    tick(4);
    checks++;
    if (bus_if.BUS_ERR !== 1'b0) begin
      errors++;
      $display("FAIL err_before_change: BUS_ERR=%b expected 0", bus_if.BUS_ERR);
    end
    bus_if.UNSYNC_BUS = 8'h3D;
    tick(1);
    checks++;
    if (bus_if.BUS_ERR !== 1'b1 || bus_if.SYNC_BUS !== 8'h3C) begin
      errors++;
      $display("FAIL err_set: BUS_ERR=%b SYNC_BUS=%h expected 1/3c", bus_if.BUS_ERR, bus_if.SYNC_BUS);
    end
    bus_if.BUS_ENABLE = 1'b0;
    tick(5);
    checks++;
    if (bus_if.BUS_ERR !== 1'b1 || bus_if.SYNC_BUS !== 8'h3C) begin
      errors++;
      $display("FAIL err_sticky: BUS_ERR=%b SYNC_BUS=%h expected 1/3c", bus_if.BUS_ERR, bus_if.SYNC_BUS);
    end
  endtask
`endif

  initial begin
    checks    = 0;
    errors    = 0;
    pulse_cnt = 0;
    RST = 1'b0;
    bus_if.BUS_ENABLE = 1'b0;
    bus_if.UNSYNC_BUS = 8'h00;

    test_reset();
    test_basic();
    test_long_enable();
    test_midop_reset();
    test_bus_ignored();
`ifdef DSYNC_ERR_EN
    test_bus_err();
`endif
    tick(2);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d captures pending, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_data_sync_pulse
